// File: rtl/lifo_thresh.sv
// Single-clock LIFO stack with registered pop data, occupancy count, and
// programmable almost-full / almost-empty thresholds plus overflow/underflow pulses.
module lifo_thresh #(
  parameter int DWIDTH   = 8,
  parameter int AWIDTH   = 4,
  parameter int AF_LEVEL = 2**AWIDTH - 2,
  parameter int AE_LEVEL = 2
) (
  input  logic              clk_i,
  input  logic              srst_i,
  input  logic              flush_i,
  input  logic              wrreq_i,
  input  logic [DWIDTH-1:0] data_i,
  input  logic              rdreq_i,
  output logic [DWIDTH-1:0] q_o,
  output logic              empty_o,
  output logic              full_o,
  output logic              almost_full_o,
  output logic              almost_empty_o,
  output logic [AWIDTH:0]   usedw_o,
  output logic              overflow_o,
  output logic              underflow_o
);

  localparam int DEPTH = 2**AWIDTH;
  localparam logic [AWIDTH:0]   DEPTH_W = (AWIDTH+1)'(DEPTH);
  localparam logic [AWIDTH:0]   AF_W    = (AWIDTH+1)'(AF_LEVEL);
  localparam logic [AWIDTH:0]   AE_W    = (AWIDTH+1)'(AE_LEVEL);
  localparam logic [AWIDTH:0]   CNT_ONE = (AWIDTH+1)'(1);
  localparam logic [AWIDTH-1:0] ADR_ONE = AWIDTH'(1);

  logic [DWIDTH-1:0] mem [DEPTH];

  logic [AWIDTH:0]   usedw_reg, usedw_next;
  logic [DWIDTH-1:0] q_reg;
  logic              ovf_reg, ovf_next;
  logic              udf_reg, udf_next;
  logic              push_acc, pop_acc;
  logic [AWIDTH-1:0] top_addr, wr_addr;

  // Address of the current top word; wraps correctly to DEPTH-1 when full.
  assign top_addr = usedw_reg[AWIDTH-1:0] - ADR_ONE;
  // A push paired with a pop overwrites the slot being popped.
  assign wr_addr  = pop_acc ? top_addr : usedw_reg[AWIDTH-1:0];

  always_comb begin
    push_acc   = 1'b0;
    pop_acc    = 1'b0;
    ovf_next   = 1'b0;
    udf_next   = 1'b0;
    usedw_next = usedw_reg;
    if (srst_i || flush_i) begin
      usedw_next = '0;
    end else begin
      push_acc = wrreq_i && (usedw_reg != DEPTH_W);
      pop_acc  = rdreq_i && (usedw_reg != '0);
      ovf_next = wrreq_i && !push_acc;
      udf_next = rdreq_i && !pop_acc;
      if (push_acc && !pop_acc) begin
        usedw_next = usedw_reg + CNT_ONE;
      end else if (pop_acc && !push_acc) begin
        usedw_next = usedw_reg - CNT_ONE;
      end
    end
  end

  // Storage array: no reset so it maps onto block RAM.
  always_ff @(posedge clk_i) begin
    if (push_acc) begin
      mem[wr_addr] <= data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      usedw_reg <= '0;
      q_reg     <= '0;
      ovf_reg   <= 1'b0;
      udf_reg   <= 1'b0;
    end else begin
      usedw_reg <= usedw_next;
      ovf_reg   <= ovf_next;
      udf_reg   <= udf_next;
      if (pop_acc) begin
        q_reg <= mem[top_addr];
      end
    end
  end

  assign q_o            = q_reg;
  assign usedw_o        = usedw_reg;
  assign overflow_o     = ovf_reg;
  assign underflow_o    = udf_reg;
  assign empty_o        = (usedw_reg == '0);
  assign full_o         = (usedw_reg == DEPTH_W);
  assign almost_full_o  = (usedw_reg >= AF_W);
  assign almost_empty_o = (usedw_reg <= AE_W);

endmodule

// File: tb/tb_lifo_thresh.sv
// Directed and random self-checking bench for lifo_thresh (8-bit, depth 16,
// AF=14, AE=2), with a queue-based stack model checked on every cycle.
module tb_lifo_thresh;

  localparam int DEPTH = 16;
  localparam int AF    = 14;
  localparam int AE    = 2;

  logic       clk_i = 1'b0;
  logic       srst_i, flush_i, wrreq_i, rdreq_i;
  logic [7:0] data_i;
  logic [7:0] q_o;
  logic       empty_o, full_o, almost_full_o, almost_empty_o;
  logic [4:0] usedw_o;
  logic       overflow_o, underflow_o;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] stack[$];
  logic [7:0] m_q   = 8'h00;
  logic       m_ovf = 1'b0;
  logic       m_udf = 1'b0;

  lifo_thresh #(.DWIDTH(8), .AWIDTH(4), .AF_LEVEL(AF), .AE_LEVEL(AE)) dut (
    .clk_i          (clk_i),
    .srst_i         (srst_i),
    .flush_i        (flush_i),
    .wrreq_i        (wrreq_i),
    .data_i         (data_i),
    .rdreq_i        (rdreq_i),
    .q_o            (q_o),
    .empty_o        (empty_o),
    .full_o         (full_o),
    .almost_full_o  (almost_full_o),
    .almost_empty_o (almost_empty_o),
    .usedw_o        (usedw_o),
    .overflow_o     (overflow_o),
    .underflow_o    (underflow_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    int n;
    n = stack.size();
    check_eq({tag, ":usedw"}, 32'(usedw_o), 32'(n));
    check_eq({tag, ":q"}, 32'(q_o), 32'(m_q));
    check_eq({tag, ":empty"}, 32'(empty_o), 32'(n == 0));
    check_eq({tag, ":full"}, 32'(full_o), 32'(n == DEPTH));
    check_eq({tag, ":afull"}, 32'(almost_full_o), 32'(n >= AF));
    check_eq({tag, ":aempty"}, 32'(almost_empty_o), 32'(n <= AE));
    check_eq({tag, ":ovf"}, 32'(overflow_o), 32'(m_ovf));
    check_eq({tag, ":udf"}, 32'(underflow_o), 32'(m_udf));
  endtask

  // One clock: drive, clock, advance the model from pre-edge state, compare.
  task automatic step(input logic rst, input logic fl, input logic wr, input logic rd,
                      input logic [7:0] d, input string tag, input bit verbose);
    int  n;
    bit  pa, pp;
    srst_i  = rst;
    flush_i = fl;
    wrreq_i = wr;
    rdreq_i = rd;
    data_i  = d;
    @(posedge clk_i);
    #1;
    if (rst) begin
      stack.delete();
      m_q = 8'h00; m_ovf = 1'b0; m_udf = 1'b0;
    end else if (fl) begin
      stack.delete();
      m_ovf = 1'b0; m_udf = 1'b0;
    end else begin
      n  = stack.size();
      pa = wr && (n < DEPTH);
      pp = rd && (n > 0);
      m_ovf = wr && !pa;
      m_udf = rd && !pp;
      if (pp) m_q = stack.pop_back();
      if (pa) stack.push_back(d);
    end
    check_all(tag);
    if (verbose)
      $display("%-8s rst=%0b fl=%0b wr=%0b rd=%0b d=%02h -> q=%02h usedw=%0d ovf=%0b udf=%0b",
               tag, rst, fl, wr, rd, d, q_o, usedw_o, overflow_o, underflow_o);
  endtask

  initial begin
    srst_i = 1'b1; flush_i = 1'b0; wrreq_i = 1'b0; rdreq_i = 1'b0; data_i = 8'h00;

    // Reset, with requests active to show they are ignored
    step(1, 1, 1, 1, 8'hEE, "reset", 1);
    check_eq("rst_usedw", 32'(usedw_o), 0);
    check_eq("rst_q", 32'(q_o), 0);
    check_eq("rst_empty", 32'(empty_o), 1);
    check_eq("rst_aempty", 32'(almost_empty_o), 1);
    check_eq("rst_full", 32'(full_o), 0);

    // Fill to full, then one rejected push
    for (int i = 1; i <= 16; i++) begin
      step(0, 0, 1, 0, 8'(i), "push", 1);
      check_eq("fill_usedw", 32'(usedw_o), 32'(i));
      check_eq("fill_afull", 32'(almost_full_o), 32'(i >= 14));
    end
    check_eq("fill_full", 32'(full_o), 1);
    step(0, 0, 1, 0, 8'hAA, "push_ovf", 1);
    check_eq("ovf_pulse", 32'(overflow_o), 1);
    check_eq("ovf_usedw", 32'(usedw_o), 16);
    step(0, 0, 0, 0, 8'h00, "idle", 1);
    check_eq("ovf_clear", 32'(overflow_o), 0);

    // Drain in reverse order, then one rejected pop
    for (int i = 1; i <= 16; i++) begin
      step(0, 0, 0, 1, 8'h00, "pop", 1);
      check_eq("drain_q", 32'(q_o), 32'(17 - i));
    end
    check_eq("drain_empty", 32'(empty_o), 1);
    step(0, 0, 0, 1, 8'h00, "pop_udf", 1);
    check_eq("udf_pulse", 32'(underflow_o), 1);
    check_eq("udf_qhold", 32'(q_o), 32'h01);
    step(0, 0, 0, 0, 8'h00, "idle", 1);
    check_eq("udf_clear", 32'(underflow_o), 0);

    // Simultaneous push/pop mid-stack
    step(0, 0, 1, 0, 8'h11, "push", 1);
    step(0, 0, 1, 0, 8'h22, "push", 1);
    step(0, 0, 1, 1, 8'h33, "both", 1);
    check_eq("both_q", 32'(q_o), 32'h22);
    check_eq("both_usedw", 32'(usedw_o), 2);
    step(0, 0, 0, 1, 8'h00, "pop", 1);
    check_eq("both_next_q", 32'(q_o), 32'h33);
    step(0, 0, 0, 1, 8'h00, "pop", 1);
    check_eq("both_last_q", 32'(q_o), 32'h11);

    // Both at full, then both at empty
    for (int i = 0; i < 16; i++) step(0, 0, 1, 0, 8'(8'h80 + i), "push", 1);
    step(0, 0, 1, 1, 8'h55, "both_full", 1);
    check_eq("bf_q", 32'(q_o), 32'h8F);
    check_eq("bf_usedw", 32'(usedw_o), 15);
    check_eq("bf_ovf", 32'(overflow_o), 1);
    for (int i = 0; i < 15; i++) begin
      step(0, 0, 0, 1, 8'h00, "pop", 1);
      check_eq("bf_drain_q", 32'(q_o), 32'(8'h8E - i));
    end
    step(0, 0, 1, 1, 8'h66, "both_emp", 1);
    check_eq("be_usedw", 32'(usedw_o), 1);
    check_eq("be_udf", 32'(underflow_o), 1);
    check_eq("be_qhold", 32'(q_o), 32'h80);
    step(0, 0, 0, 1, 8'h00, "pop", 1);
    check_eq("be_pop_q", 32'(q_o), 32'h66);

    // Flush with a simultaneous push
    for (int i = 0; i < 5; i++) step(0, 0, 1, 0, 8'(8'hC0 + i), "push", 1);
    step(0, 1, 1, 0, 8'h77, "flush", 1);
    check_eq("fl_usedw", 32'(usedw_o), 0);
    check_eq("fl_ovf", 32'(overflow_o), 0);
    check_eq("fl_udf", 32'(underflow_o), 0);
    check_eq("fl_qhold", 32'(q_o), 32'h66);

    // Reset mid-operation
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 8'(8'hD0 + i), "push", 1);
    step(1, 0, 0, 1, 8'h00, "reset", 1);
    check_eq("mr_usedw", 32'(usedw_o), 0);
    check_eq("mr_q", 32'(q_o), 0);
    check_eq("mr_empty", 32'(empty_o), 1);
    check_eq("mr_afull", 32'(almost_full_o), 0);
    step(0, 0, 0, 1, 8'h00, "pop_udf", 1);
    check_eq("mr_udf", 32'(underflow_o), 1);
    check_eq("mr_qzero", 32'(q_o), 0);

    // Random mix in push-biased, pop-biased and balanced phases
    for (int c = 0; c < 2400; c++) begin
      int  r, ph;
      logic wr, rd, fl, rs;
      ph = (c / 200) % 3;
      r  = int'($urandom_range(0, 99));
      fl = (r == 0);
      rs = (ph == 2) && (r == 99);
      case (ph)
        0:       begin wr = ($urandom_range(0, 99) < 75); rd = ($urandom_range(0, 99) < 30); end
        1:       begin wr = ($urandom_range(0, 99) < 30); rd = ($urandom_range(0, 99) < 75); end
        default: begin wr = ($urandom_range(0, 99) < 50); rd = ($urandom_range(0, 99) < 50); end
      endcase
      step(rs, fl, wr, rd, 8'($urandom), "rand", 0);
    end
    $display("random phase: 2400 cycles done");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
